// File: rtl/fpga_top.sv
// -----------------------------------------------------------------------------
// fpga_top
//   UART echo block. Bytes received on rx (8N1) are echoed back on tx, and the
//   low nibble of the most recent good byte is shown on leds. A one-entry
//   pending buffer decouples the receiver from the transmitter, so the two run
//   concurrently; if a new byte arrives while one is still pending, the newer
//   byte replaces it.
//
// Parameters
//   CLK_FREQ  system clock frequency in Hz
//   BAUD      UART bit rate; CLKS_PER_BIT = CLK_FREQ / BAUD (truncated)
//
// Ports
//   clk    in   1  system clock, rising edge
//   rst_n  in   1  asynchronous active-low reset
//   rx     in   1  UART serial input, idles high
//   tx     out  1  UART serial output (registered), idles high
//   leds   out  4  low nibble of the last validly received byte
// -----------------------------------------------------------------------------
module fpga_top #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 9600
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic       tx,
   output logic [3:0] leds
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   // input synchronizer
   logic             rx_meta_q;
   logic             rx_sync_q;

   // receiver
   uart_state_e      rx_state_q, rx_state_d;
   logic [CNT_W-1:0] rx_cnt_q,   rx_cnt_d;
   logic [2:0]       rx_idx_q,   rx_idx_d;
   logic [7:0]       rx_shift_q, rx_shift_d;
   logic             rx_valid;

   // pending buffer and leds
   logic             pend_full_q, pend_full_d;
   logic [7:0]       pend_byte_q, pend_byte_d;
   logic [3:0]       leds_q,      leds_d;

   // transmitter
   uart_state_e      tx_state_q, tx_state_d;
   logic [CNT_W-1:0] tx_cnt_q,   tx_cnt_d;
   logic [2:0]       tx_idx_q,   tx_idx_d;
   logic [7:0]       tx_shift_q, tx_shift_d;
   logic             tx_q,       tx_d;
   logic             tx_load;

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q   <= 1'b1;
         rx_sync_q   <= 1'b1;
         rx_state_q  <= ST_IDLE;
         rx_cnt_q    <= '0;
         rx_idx_q    <= '0;
         rx_shift_q  <= '0;
         pend_full_q <= 1'b0;
         pend_byte_q <= '0;
         leds_q      <= '0;
         tx_state_q  <= ST_IDLE;
         tx_cnt_q    <= '0;
         tx_idx_q    <= '0;
         tx_shift_q  <= '0;
         tx_q        <= 1'b1;
      end else begin
         rx_meta_q   <= rx;
         rx_sync_q   <= rx_meta_q;
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_idx_q    <= rx_idx_d;
         rx_shift_q  <= rx_shift_d;
         pend_full_q <= pend_full_d;
         pend_byte_q <= pend_byte_d;
         leds_q      <= leds_d;
         tx_state_q  <= tx_state_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_idx_q    <= tx_idx_d;
         tx_shift_q  <= tx_shift_d;
         tx_q        <= tx_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Receiver next-state logic. The counter restarts at every sample point, so
   // after the mid-start sample every later sample lands one full bit later,
   // i.e. in the middle of each data bit and of the stop bit.
   // ---------------------------------------------------------------------------
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_idx_d   = rx_idx_q;
      rx_shift_d = rx_shift_q;
      rx_valid   = 1'b0;

      case (rx_state_q)
         ST_IDLE: begin
            rx_cnt_d = '0;
            rx_idx_d = '0;
            if (!rx_sync_q) begin
               rx_state_d = ST_START;
            end
         end

         ST_START: begin
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d = '0;
               // line back high at mid-start: treat as a glitch
               rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_ONE;
            end
         end

         ST_DATA: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               if (rx_idx_q == 3'd7) begin
                  rx_state_d = ST_STOP;
               end else begin
                  rx_idx_d = rx_idx_q + 3'd1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_ONE;
            end
         end

         ST_STOP: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_state_d = ST_IDLE;
               // a low stop bit is a framing error: byte is dropped silently
               rx_valid   = rx_sync_q;
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_ONE;
            end
         end

         default: rx_state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Pending buffer and leds. A write from the receiver takes priority over the
   // transmitter's clear, so a byte arriving on the same cycle the transmitter
   // picks up the previous one is kept rather than lost.
   // ---------------------------------------------------------------------------
   always_comb begin
      pend_full_d = pend_full_q;
      pend_byte_d = pend_byte_q;
      leds_d      = leds_q;

      if (tx_load) begin
         pend_full_d = 1'b0;
      end
      if (rx_valid) begin
         pend_full_d = 1'b1;
         pend_byte_d = rx_shift_q;
         leds_d      = rx_shift_q[3:0];
      end
   end

   // ---------------------------------------------------------------------------
   // Transmitter next-state logic. tx_d carries the level of the bit being
   // entered, so tx_q changes only on bit boundaries and is glitch-free.
   // ---------------------------------------------------------------------------
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_idx_d   = tx_idx_q;
      tx_shift_d = tx_shift_q;
      tx_d       = tx_q;
      tx_load    = 1'b0;

      case (tx_state_q)
         ST_IDLE: begin
            tx_d     = 1'b1;
            tx_cnt_d = '0;
            tx_idx_d = '0;
            if (pend_full_q) begin
               tx_load    = 1'b1;
               tx_shift_d = pend_byte_q;
               tx_d       = 1'b0;
               tx_state_d = ST_START;
            end
         end

         ST_START: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_d       = tx_shift_q[0];
               tx_state_d = ST_DATA;
            end else begin
               tx_cnt_d = tx_cnt_q + CNT_ONE;
            end
         end

         ST_DATA: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d = '0;
               if (tx_idx_q == 3'd7) begin
                  tx_d       = 1'b1;
                  tx_state_d = ST_STOP;
               end else begin
                  tx_idx_d   = tx_idx_q + 3'd1;
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
                  tx_d       = tx_shift_q[1];
               end
            end else begin
               tx_cnt_d = tx_cnt_q + CNT_ONE;
            end
         end

         ST_STOP: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_state_d = ST_IDLE;
            end else begin
               tx_cnt_d = tx_cnt_q + CNT_ONE;
            end
         end

         default: tx_state_d = ST_IDLE;
      endcase
   end

   assign tx   = tx_q;
   assign leds = leds_q;

endmodule

// File: tb/tb_fpga_top.sv
// -----------------------------------------------------------------------------
// tb_fpga_top
//   Drives UART frames into fpga_top and decodes the echoed frames on tx.
//   Expected echoes and leds come from a frame-level model: every frame with a
//   good stop bit is echoed in order and sets leds to its low nibble; glitches
//   and framing errors produce nothing.
// -----------------------------------------------------------------------------
module tb_fpga_top;

   localparam int CLK_FREQ = 160;
   localparam int BAUD     = 10;
   localparam int CPB      = CLK_FREQ / BAUD;   // 16 clocks per bit

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic       rx    = 1'b1;
   logic       tx;
   logic [3:0] leds;

   fpga_top #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rx    (rx),
      .tx    (tx),
      .leds  (leds)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;

   logic [7:0] exp_q[$];
   logic [3:0] exp_leds   = 4'h0;
   int         frames_seen = 0;
   int         last_fall   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // tx frame decoder: samples each bit in its middle
   initial begin : monitor
      logic [7:0] b;
      logic       st, sp;
      bit         ab;
      int         fall;
      forever begin
         @(negedge clk);
         if (rst_n && tx === 1'b0) begin
            ab   = 1'b0;
            fall = cyc;
            b    = '0;
            repeat (CPB/2) begin @(negedge clk); if (!rst_n) ab = 1'b1; end
            st = tx;
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) begin @(negedge clk); if (!rst_n) ab = 1'b1; end
               b[i] = tx;
            end
            repeat (CPB) begin @(negedge clk); if (!rst_n) ab = 1'b1; end
            sp = tx;
            if (!ab) begin
               frames_seen++;
               last_fall = fall;
               chk("tx_start_bit", st, 0);
               chk("tx_stop_bit", sp, 1);
               chk("tx_frame_expected", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) chk("tx_echo_byte", b, exp_q.pop_front());
            end
         end
      end
   end

   task automatic drive_frame(input logic [7:0] b, input logic stop, output int t0);
      rx = 1'b0;
      t0 = cyc;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      int t0;
      drive_frame(b, stop, t0);
      if (stop) begin
         exp_q.push_back(b);
         exp_leds = b[3:0];
      end
      chk("leds_after_frame", leds, exp_leds);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 40*CPB) begin
         @(negedge clk);
         n++;
      end
      chk("echo_drain", exp_q.size(), 0);
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_idle_echo(input logic [7:0] b);
      int t0, f0, lat;
      f0 = frames_seen;
      drive_frame(b, 1'b1, t0);
      exp_q.push_back(b);
      exp_leds = b[3:0];
      chk("leds_after_frame", leds, exp_leds);
      wait_drain();
      chk("echo_count", frames_seen, f0 + 1);
      lat = last_fall - t0;
      chk("echo_latency_in_range", (lat >= 9*CPB) && (lat <= 9*CPB + CPB/2 + 6), 1);
   endtask

   task automatic glitch(input int len);
      rx = 1'b0;
      repeat (len) @(negedge clk);
      rx = 1'b1;
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : main
      int f0, n, t0;
      logic [7:0] b;
      int kind;

      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_tx", tx, 1);
      chk("reset_leds", leds, 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("post_reset_tx", tx, 1);
      chk("post_reset_leds", leds, 0);

      // directed frames
      send_idle_echo(8'hCC);
      chk("leds_cc", leds, 4'b1100);
      send_idle_echo(8'hAA);
      chk("leds_aa", leds, 4'b1010);

      // short low pulse well under half a bit
      f0 = frames_seen;
      glitch(5);
      repeat (12*CPB) @(negedge clk);
      chk("glitch_no_tx", frames_seen, f0);
      chk("glitch_leds", leds, 4'b1010);
      chk("glitch_tx_idle", tx, 1);

      // framing error
      f0 = frames_seen;
      send_byte(8'h5F, 1'b0);
      repeat (12*CPB) @(negedge clk);
      chk("bad_stop_no_tx", frames_seen, f0);
      chk("bad_stop_leds", leds, 4'b1010);

      // back-to-back frames, second arrives while tx is busy
      f0 = frames_seen;
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      wait_drain();
      chk("b2b_frames", frames_seen, f0 + 2);
      chk("b2b_leds", leds, 4'b0100);

      // randomized mix of good frames, framing errors and glitches
      for (int k = 0; k < 24; k++) begin
         b    = 8'($urandom);
         kind = $urandom_range(0, 5);
         if (kind == 0) begin
            glitch($urandom_range(1, CPB/2 - 2));
            repeat (CPB) @(negedge clk);
         end else if (kind == 1) begin
            send_byte(b, 1'b0);
            repeat (CPB + $urandom_range(0, CPB)) @(negedge clk);
         end else begin
            send_byte(b, 1'b1);
            repeat ($urandom_range(0, CPB)) @(negedge clk);
         end
      end
      wait_drain();
      chk("random_leds_final", leds, exp_leds);

      // reset in the middle of data bit 4 of an incoming frame
      send_idle_echo(8'h3B);
      b = 8'hE7;
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = b[4];
      repeat (CPB/2) @(negedge clk);
      f0 = frames_seen;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_rx_tx", tx, 1);
      chk("rst_mid_rx_leds", leds, 0);
      exp_leds = 4'h0;
      rx = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (14*CPB) @(negedge clk);
      chk("rst_mid_rx_no_echo", frames_seen, f0);
      chk("rst_mid_rx_leds_hold", leds, 0);

      // reset while an echo is going out
      drive_frame(8'hF0, 1'b1, t0);
      exp_q.push_back(8'hF0);
      n = 0;
      while (tx !== 1'b0 && n < 4*CPB) begin
         @(negedge clk);
         n++;
      end
      chk("echo_start_seen", tx, 0);
      repeat (3*CPB + 3) @(negedge clk);
      chk("mid_tx_level_low", tx, 0);
      f0 = frames_seen;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_tx_tx", tx, 1);
      chk("rst_mid_tx_leds", leds, 0);
      exp_q.delete();
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (14*CPB) @(negedge clk);
      chk("rst_mid_tx_no_frame", frames_seen, f0);
      chk("rst_mid_tx_tx_idle", tx, 1);

      // receiver is usable straight after reset
      send_idle_echo(8'h96);
      chk("post_reset_leds_96", leds, 4'h6);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
